wordlit_op_pipe: RTL and testbench
==================================

Name: wordlit_op_pipe

Overview:
- Parametrised successor to the single-cycle word-literal XOR block.
- Resizes an IN_W input word to OUT_W, then combines it with a compile-time literal KEY using a selectable operator.
- Passes the result through a STAGES-deep valid-tagged pipeline.
- Tracks emitted results and halts after MAX_OUT outputs, signalling termination on __continue.
- Sits at the device boundary as the top-level data path for streaming word transforms.

Parameters:
- IN_W, 8: input word width (≥1).
- OUT_W, 16: output word width (≥1).
- KEY, 16'h0001: OUT_W-bit literal operand.
- MODE, 0: operator select. 0 = XOR, 1 = ADD mod 2^OUT_W, 2 = SUB (ext − KEY) mod 2^OUT_W.
- STAGES, 2: pipeline depth, which is also the latency (≥1).
- MAX_OUT, 0: number of outputs before halt. 0 = never halt.

Ports:
- clk, input, 1: system clock. All state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- __in0, input, IN_W: input word.
- __in_valid, input, 1: __in0 is valid this cycle.
- __out0, output, OUT_W: result word.
- __out_valid, output, 1: __out0 carries a new result this cycle.
- __continue, output, 1: 1 while running, 0 once halted.

Behaviour:
- Reset: asserting rst immediately clears all pipeline data and valid bits, the output counter and the state.
  - __out0 = 0, __out_valid = 0, __continue = 1.
  - Reset mid-operation discards every in-flight sample. No partial output appears after release.
- Resize:
  - IN_W ≤ OUT_W: ext = zero-extend(__in0).
  - IN_W > OUT_W: ext = __in0[OUT_W-1:0] (truncate high bits).
- Operator: per MODE, result is exactly OUT_W bits and carries/borrows are discarded. Unsupported MODE values are a compile-time error.
- Pipeline:
  - Stage 0 captures {__in_valid, op(ext, KEY)} on each edge while RUN.
  - Each later stage shifts every cycle, with no stall.
  - __out0/__out_valid are driven by the last stage register.
  - A sample accepted at edge N appears at edge N+STAGES−1, so latency is STAGES cycles from input presentation.
  - Back-to-back inputs give back-to-back outputs.
  - Invalid input cycles propagate as bubbles: __out_valid = 0 and __out0 holds its previous value.
- States:
  - RUN: inputs accepted and __continue = 1.
  - HALT: entered on the edge on which the counter registers the MAX_OUT-th output. __continue = 0 from the following cycle.
  - In HALT, stage-0 valid is forced to 0 and __in_valid is ignored. Samples already in flight still drain and are counted nowhere.
  - HALT is left only via rst.
- Counter:
  - Width clog2(MAX_OUT+1). Increments when __out_valid = 1 in RUN.
  - Saturates at MAX_OUT and never wraps.
  - With MAX_OUT = 0 the counter and HALT are absent and __continue is tied to 1.
- Simultaneous rst and __in_valid: rst wins.

Optional Feature:
- Macro WORDLIT_OP_ACCUM_EN.
- Defined:
  - An OUT_W accumulator register (reset 0) XORs in each valid final-stage result.
  - __out0 presents the updated accumulator value in the same cycle __out_valid = 1. Latency is unchanged.
  - The accumulator is cleared only by rst and holds through HALT.
- Undefined: no accumulator register exists and __out0 is the per-sample result.

Test Plan:
- Reset with defaults: assert rst mid-clock with no clk edge -> __out0 = 16'h0000, __out_valid = 0, __continue = 1 immediately.
- Defaults, single samples: __in0 = 8'h00 valid -> two cycles later __out0 = 16'h0001 with __out_valid = 1. Then 8'hFF -> 16'h00FE.
- Streaming: 8'h10, 8'h11, 8'h12 on consecutive cycles, then one idle cycle, then 8'h13 -> outputs 16'h0011, 16'h0010, 16'h0013 on consecutive cycles, one bubble, then 16'h0012.
- MAX_OUT = 4, continuous valid input -> exactly 4 __out_valid pulses. __continue falls the cycle after the 4th pulse, stays 0, and further inputs produce no output.
- MODE = 1, KEY = 16'hFFFF, __in0 = 8'h01 -> 16'h0000 (wrap). MODE = 2, KEY = 16'h0002, __in0 = 8'h01 -> 16'hFFFF.
- Reset mid-flight: present 8'h05, assert rst one cycle later -> no __out_valid after release.
- With WORDLIT_OP_ACCUM_EN: 8'h00 then 8'hFF -> 16'h0001 then 16'h00FF.

Source files
------------

// File: rtl/wordlit_op_pipe.sv
// wordlit_op_pipe: resize a word, combine it with KEY, and pass it down a valid-tagged pipe.
// Optional XOR accumulator on the output, enabled by defining WORDLIT_OP_ACCUM_EN.
module wordlit_op_pipe #(
   parameter int               IN_W    = 8,
   parameter int               OUT_W   = 16,
   parameter logic [OUT_W-1:0] KEY     = OUT_W'(1),
   parameter int               MODE    = 0,
   parameter int               STAGES  = 2,
   parameter int               MAX_OUT = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IN_W-1:0]  __in0,
   input  logic             __in_valid,
   output logic [OUT_W-1:0] __out0,
   output logic             __out_valid,
   output logic             __continue
);

   logic             run;
   logic [OUT_W-1:0] ext;
   logic [OUT_W-1:0] op_res;

   if (IN_W <= OUT_W) begin : g_zext
      assign ext = OUT_W'(__in0);
   end else begin : g_trunc
      assign ext = __in0[OUT_W-1:0];
   end

   if (MODE == 0) begin : g_xor
      assign op_res = ext ^ KEY;
   end else if (MODE == 1) begin : g_add
      assign op_res = ext + KEY;
   end else if (MODE == 2) begin : g_sub
      assign op_res = ext - KEY;
   end else begin : g_bad_mode
      $error("wordlit_op_pipe: unsupported MODE");
      assign op_res = '0;
   end

   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] v_nx;
   logic [OUT_W-1:0]  d_q  [STAGES];
   logic [OUT_W-1:0]  d_nx [STAGES];

   // Next value of each stage: stage 0 takes the operator, later stages shift.
   always_comb begin
      v_nx[0] = __in_valid & run;
      d_nx[0] = op_res;
      for (int i = 1; i < STAGES; i++) begin
         v_nx[i] = v_q[i-1];
         d_nx[i] = d_q[i-1];
      end
   end

   // Stage registers; data only loads on valid so bubbles hold the old word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q <= '0;
         for (int i = 0; i < STAGES; i++) d_q[i] <= '0;
      end else begin
         v_q <= v_nx;
         for (int i = 0; i < STAGES; i++) begin
            if (v_nx[i]) d_q[i] <= d_nx[i];
         end
      end
   end

   assign __out_valid = v_q[STAGES-1];

`ifdef WORDLIT_OP_ACCUM_EN
   logic [OUT_W-1:0] acc_q;

   // Fold each result entering the last stage so the output shows it at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) acc_q <= '0;
      else if (v_nx[STAGES-1]) acc_q <= acc_q ^ d_nx[STAGES-1];
   end

   assign __out0 = acc_q;
`else
   assign __out0 = d_q[STAGES-1];
`endif

   if (MAX_OUT == 0) begin : g_free
      assign run = 1'b1;
   end else begin : g_cnt
      localparam int CW = $clog2(MAX_OUT + 1);
      typedef enum logic {S_RUN, S_HALT} state_t;
      state_t        state;
      state_t        state_nx;
      logic [CW-1:0] cnt;

      // State register.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) state <= S_RUN;
         else     state <= state_nx;
      end

      // Halt on the edge that counts the last allowed output.
      always_comb begin
         state_nx = state;
         unique case (state)
            S_RUN: begin
               if (__out_valid && cnt == CW'(MAX_OUT - 1))
                  state_nx = S_HALT;
            end
            S_HALT: state_nx = S_HALT;
         endcase
      end

      // Accept inputs only while running.
      always_comb run = (state == S_RUN);

      // Saturating count of outputs seen while running.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) cnt <= '0;
         else if (run && __out_valid && cnt != CW'(MAX_OUT))
            cnt <= cnt + 1'b1;
      end
   end

   assign __continue = run;

endmodule

// File: tb/tb_wordlit_op_pipe.sv
// tb_wordlit_op_pipe: vector table, corner sequences and a random run
// against a cycle-indexed reference model, over four parameter sets.
module tb_wordlit_op_pipe;

   localparam int LAT = 2;
   localparam int NM  = 4;

   logic        clk;
   logic        rst;
   logic [7:0]  in0;
   logic        in_valid;
   logic [15:0] o [NM];
   logic [NM-1:0] ov;
   logic [NM-1:0] oc;

   wordlit_op_pipe u_def (
      .clk(clk), .rst(rst), .__in0(in0), .__in_valid(in_valid),
      .__out0(o[0]), .__out_valid(ov[0]), .__continue(oc[0]));

   wordlit_op_pipe #(.MAX_OUT(4)) u_halt (
      .clk(clk), .rst(rst), .__in0(in0), .__in_valid(in_valid),
      .__out0(o[1]), .__out_valid(ov[1]), .__continue(oc[1]));

   wordlit_op_pipe #(.MODE(1), .KEY(16'hFFFF)) u_add (
      .clk(clk), .rst(rst), .__in0(in0), .__in_valid(in_valid),
      .__out0(o[2]), .__out_valid(ov[2]), .__continue(oc[2]));

   wordlit_op_pipe #(.MODE(2), .KEY(16'h0002)) u_sub (
      .clk(clk), .rst(rst), .__in0(in0), .__in_valid(in_valid),
      .__out0(o[3]), .__out_valid(ov[3]), .__continue(oc[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   int          mmode [NM] = '{0, 0, 1, 2};
   logic [15:0] mkey  [NM] = '{16'h0001, 16'h0001, 16'hFFFF, 16'h0002};
   int          mmax  [NM] = '{0, 4, 0, 0};
   bit          mrun  [NM];
   int          mcnt  [NM];
   bit          vis_v [NM];
   logic [15:0] vis_d [NM];
   logic [15:0] macc  [NM];
   bit          sv [NM][4096];
   logic [15:0] sd [NM][4096];
   int          ecount = 0;

   typedef struct {
      logic [7:0]  in;
      logic        v;
      logic [15:0] eo;
      logic        ev;
   } vec_t;
   vec_t tbl [9];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] ref_op(input int m, input logic [7:0] x);
      int e, k;
      e = int'(x);
      k = int'(mkey[m]);
      case (mmode[m])
         1:       return 16'((e + k) % 65536);
         2:       return 16'((e - k + 65536) % 65536);
         default: return 16'(e) ^ mkey[m];
      endcase
   endfunction

   task automatic model_reset();
      for (int m = 0; m < NM; m++) begin
         mrun[m] = 1'b1;
         mcnt[m] = 0;
         vis_v[m] = 1'b0;
         vis_d[m] = 16'h0000;
         macc[m] = 16'h0000;
         for (int k = 0; k < LAT + 2; k++) sv[m][ecount + k] = 1'b0;
      end
   endtask

   task automatic check_all(input string tag);
      for (int m = 0; m < NM; m++) begin
         chk($sformatf("%s_valid%0d", tag, m), 32'(ov[m]), 32'(vis_v[m]));
         chk($sformatf("%s_out%0d", tag, m), 32'(o[m]), 32'(vis_d[m]));
         chk($sformatf("%s_cont%0d", tag, m), 32'(oc[m]), 32'(mrun[m]));
      end
   endtask

   // one clock with the currently driven inputs, then compare everything
   task automatic step(input string tag);
      int e;
      bit nr;
      e = ecount + 1;
      for (int m = 0; m < NM; m++) begin
         nr = mrun[m];
         if (mrun[m] && mmax[m] != 0 && vis_v[m]) begin
            mcnt[m]++;
            if (mcnt[m] == mmax[m]) nr = 1'b0;
         end
         sv[m][e + LAT - 1] = 1'b0;
         if (mrun[m] && in_valid) begin
            sv[m][e + LAT - 1] = 1'b1;
            sd[m][e + LAT - 1] = ref_op(m, in0);
         end
         mrun[m] = nr;
      end
      @(posedge clk);
      #1;
      ecount = e;
      for (int m = 0; m < NM; m++) begin
         vis_v[m] = sv[m][e];
         if (vis_v[m]) begin
`ifdef WORDLIT_OP_ACCUM_EN
            macc[m] = macc[m] ^ sd[m][e];
            vis_d[m] = macc[m];
`else
            vis_d[m] = sd[m][e];
`endif
         end
      end
      check_all(tag);
   endtask

   // asynchronous reset asserted mid-cycle, checked before any edge
   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b1;
      #1;
      for (int m = 0; m < NM; m++) begin
         chk($sformatf("rst_out%0d", m), 32'(o[m]), 32'h0);
         chk($sformatf("rst_valid%0d", m), 32'(ov[m]), 32'h0);
         chk($sformatf("rst_cont%0d", m), 32'(oc[m]), 32'h1);
      end
      @(posedge clk);
      #1;
      ecount++;
      model_reset();
      #2;
      rst = 1'b0;
      in_valid = 1'b0;
   endtask

   int n_run, n_tot, m_tot, n_flight;

   initial begin
`ifdef WORDLIT_OP_ACCUM_EN
      tbl[0] = '{8'h00, 1'b1, 16'h0000, 1'b0};
      tbl[1] = '{8'hFF, 1'b1, 16'h0001, 1'b1};
      tbl[2] = '{8'h10, 1'b1, 16'h00FF, 1'b1};
      tbl[3] = '{8'h11, 1'b1, 16'h00EE, 1'b1};
      tbl[4] = '{8'h12, 1'b1, 16'h00FE, 1'b1};
      tbl[5] = '{8'h00, 1'b0, 16'h00ED, 1'b1};
      tbl[6] = '{8'h13, 1'b1, 16'h00ED, 1'b0};
      tbl[7] = '{8'h00, 1'b0, 16'h00FF, 1'b1};
      tbl[8] = '{8'h00, 1'b0, 16'h00FF, 1'b0};
`else
      tbl[0] = '{8'h00, 1'b1, 16'h0000, 1'b0};
      tbl[1] = '{8'hFF, 1'b1, 16'h0001, 1'b1};
      tbl[2] = '{8'h10, 1'b1, 16'h00FE, 1'b1};
      tbl[3] = '{8'h11, 1'b1, 16'h0011, 1'b1};
      tbl[4] = '{8'h12, 1'b1, 16'h0010, 1'b1};
      tbl[5] = '{8'h00, 1'b0, 16'h0013, 1'b1};
      tbl[6] = '{8'h13, 1'b1, 16'h0013, 1'b0};
      tbl[7] = '{8'h00, 1'b0, 16'h0012, 1'b1};
      tbl[8] = '{8'h00, 1'b0, 16'h0012, 1'b0};
`endif
      rst = 1'b0;
      in0 = 8'h00;
      in_valid = 1'b0;
      #2;
      do_reset();

      // single samples and streaming with a bubble
      for (int i = 0; i < 9; i++) begin
         in0 = tbl[i].in;
         in_valid = tbl[i].v;
         step("tbl");
         chk($sformatf("vec%0d_out", i), 32'(o[0]), 32'(tbl[i].eo));
         chk($sformatf("vec%0d_valid", i), 32'(ov[0]), 32'(tbl[i].ev));
      end

      // modular add and subtract wrap
      do_reset();
      in0 = 8'h01;
      in_valid = 1'b1;
      step("mode");
      in_valid = 1'b0;
      step("mode");
`ifndef WORDLIT_OP_ACCUM_EN
      chk("add_wrap", 32'(o[2]), 32'h0000);
      chk("sub_wrap", 32'(o[3]), 32'hFFFF);
`endif
      chk("add_wrap_valid", 32'(ov[2]), 32'h1);
      chk("sub_wrap_valid", 32'(ov[3]), 32'h1);

      // MAX_OUT=4 with continuous input, then the drain
      do_reset();
      n_run = 0;
      n_tot = 0;
      m_tot = 0;
      for (int i = 0; i < 14; i++) begin
         in0 = 8'($urandom);
         in_valid = 1'b1;
         step("halt");
         if (ov[1] && oc[1]) n_run++;
         if (ov[1]) n_tot++;
         if (vis_v[1]) m_tot++;
      end
      chk("halt_pulses_running", 32'(n_run), 32'd4);
      chk("halt_pulses_total", 32'(n_tot), 32'(m_tot));
      chk("halt_continue", 32'(oc[1]), 32'h0);
      chk("halt_no_output", 32'(ov[1]), 32'h0);

      // reset one cycle after a sample enters
      do_reset();
      in0 = 8'h05;
      in_valid = 1'b1;
      step("flight");
      in_valid = 1'b0;
      do_reset();
      n_flight = 0;
      for (int i = 0; i < 5; i++) begin
         step("flight");
         n_flight += int'(ov[0]) + int'(ov[2]) + int'(ov[3]);
      end
      chk("flight_no_output", 32'(n_flight), 32'd0);

      // random traffic with occasional resets
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 120) == 0) do_reset();
         in0 = 8'($urandom);
         in_valid = ($urandom_range(0, 3) != 0);
         step("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
